// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic register chain of STAGES slots plus one skid entry.
// Words advance whenever the slot above is free or draining, so bubbles collapse.
// InReady comes only from Reset and the skid valid bit, never from OutReady.
// Flush clears every valid bit and leaves the data registers as they were.
// Build option: define PIPE_STAGE_ELASTIC_PERF_EN to add the StallCount output.
module pipe_stage_elastic #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    input  logic             Flush,
    output logic [3:0]       Occupancy
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    ,
    output logic [31:0]      StallCount
`endif
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]            slotValid;
    logic [STAGES-1:0]            slotValidNext;
    logic [STAGES-1:0]            slotAdvance;
    logic [STAGES-1:0][WIDTH-1:0] slotData;
    logic [STAGES-1:0][WIDTH-1:0] slotDataNext;
    logic                         skidValid;
    logic                         skidValidNext;
    logic [WIDTH-1:0]             skidData;
    logic [WIDTH-1:0]             skidDataNext;
    logic                         accept;
    logic                         slot0Open;

    assign InReady   = Reset & ~skidValid;
    assign accept    = InValid & InReady;
    assign OutValid  = slotValid[LAST];
    assign OutData   = slotData[LAST];
    assign slot0Open = ~slotValid[0] | slotAdvance[0];

    // A full slot moves up when the output drains or any slot above it is empty.
    always_comb begin
        logic roomAbove;
        roomAbove   = OutReady;
        slotAdvance = '0;
        for (int i = LAST; i >= 0; i--) begin
            slotAdvance[i] = slotValid[i] & roomAbove;
            roomAbove      = roomAbove | ~slotValid[i];
        end
    end

    // Next-state for slots and skid; the skid always has priority into slot 0.
    always_comb begin
        slotValidNext = slotValid;
        slotDataNext  = slotData;
        skidValidNext = skidValid;
        skidDataNext  = skidData;
        for (int i = LAST; i >= 1; i--) begin
            if (slotAdvance[i-1]) begin
                slotValidNext[i] = 1'b1;
                slotDataNext[i]  = slotData[i-1];
            end else if (slotAdvance[i]) begin
                slotValidNext[i] = 1'b0;
            end
        end
        if (slot0Open) begin
            if (skidValid) begin
                slotValidNext[0] = 1'b1;
                slotDataNext[0]  = skidData;
                skidValidNext    = 1'b0;
            end else if (accept) begin
                slotValidNext[0] = 1'b1;
                slotDataNext[0]  = InData;
            end else begin
                slotValidNext[0] = 1'b0;
            end
        end else if (accept) begin
            skidValidNext = 1'b1;
            skidDataNext  = InData;
        end
    end

    // State registers: Flush squashes valid bits only, data keeps its contents.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            slotValid <= '0;
            skidValid <= 1'b0;
            slotData  <= '0;
            skidData  <= '0;
        end else begin
            slotValid <= Flush ? '0 : slotValidNext;
            skidValid <= ~Flush & skidValidNext;
            if (!Flush) begin
                slotData <= slotDataNext;
                skidData <= skidDataNext;
            end
        end
    end

    // Occupancy is the population count of every valid bit, skid included.
    always_comb begin
        Occupancy = {3'b000, skidValid};
        for (int i = 0; i < STAGES; i++) begin
            Occupancy = Occupancy + {3'b000, slotValid[i]};
        end
    end

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    // Saturating count of edges where the output word is held by downstream.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
        end else if (OutValid && !OutReady && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: four instances (STAGES=1..4) share one stimulus stream.
// Each instance has a queue model: every held word carries a position
// (-1 = skid, STAGES-1 = output slot); each edge pops a consumed head and moves
// every word up as far as the word ahead of it allows.
`timescale 1ns/1ps
module tb_pipe_stage_elastic;
    localparam int NLANE = 4;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             inValid = 1'b0;
    logic             outReady = 1'b0;
    logic             flush = 1'b0;
    logic [7:0]       inData = 8'h00;
    logic [NLANE-1:0] inReadyW;
    logic [NLANE-1:0] outValidW;
    logic [7:0]       outDataW [NLANE];
    logic [3:0]       occW [NLANE];
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    logic [31:0]      stallW [NLANE];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NLANE; g++) begin : gLane
        localparam int ST = g + 1;
        logic [7:0]  mData[$];
        int          mPos[$];
        logic [31:0] mStall = 32'd0;

        pipe_stage_elastic #(.WIDTH(8), .STAGES(ST)) dut (
            .Clk      (clk),
            .Reset    (rstN),
            .InValid  (inValid),
            .InReady  (inReadyW[g]),
            .InData   (inData),
            .OutValid (outValidW[g]),
            .OutReady (outReady),
            .OutData  (outDataW[g]),
            .Flush    (flush),
            .Occupancy(occW[g])
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
            ,
            .StallCount(stallW[g])
`endif
        );

        // Reference model update at each edge.
        always @(posedge clk or negedge rstN) begin
            bit rdy;
            bit headOut;
            int lim;
            int np;
            if (!rstN) begin
                mData.delete();
                mPos.delete();
                mStall = 32'd0;
            end else begin
                rdy     = (mData.size() <= ST);
                headOut = (mData.size() > 0) && (mPos[0] == ST - 1);
                if (headOut && !outReady && (mStall != 32'hFFFF_FFFF)) mStall = mStall + 32'd1;
                if (flush) begin
                    mData.delete();
                    mPos.delete();
                end else begin
                    if (headOut && outReady) begin
                        void'(mData.pop_front());
                        void'(mPos.pop_front());
                    end
                    lim = ST - 1;
                    foreach (mPos[i]) begin
                        np = mPos[i] + 1;
                        if (np > lim) np = lim;
                        mPos[i] = np;
                        lim = np - 1;
                    end
                    if (inValid && rdy) begin
                        mData.push_back(inData);
                        mPos.push_back((lim >= 0) ? 0 : -1);
                    end
                end
            end
        end

        // Compare DUT against the model on every falling edge.
        always @(negedge clk) begin
            bit ev;
            ev = (mData.size() > 0) && (mPos[0] == ST - 1);
            check($sformatf("L%0d InReady", ST), 32'(inReadyW[g]), 32'(rstN && (mData.size() <= ST)));
            check($sformatf("L%0d OutValid", ST), 32'(outValidW[g]), 32'(ev));
            check($sformatf("L%0d Occupancy", ST), 32'(occW[g]), 32'(mData.size()));
            if (ev) check($sformatf("L%0d OutData", ST), 32'(outDataW[g]), 32'(mData[0]));
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
            check($sformatf("L%0d StallCount", ST), stallW[g], mStall);
`endif
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doFlush();
        flush = 1'b1;
        inValid = 1'b0;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] expSeq[4];
        bit acc;
        int deliveries;

        // Reset state
        cycle();
        cycle();
        check("reset OutValid", 32'(outValidW), 32'd0);
        check("reset OutData", 32'(outDataW[2]), 32'd0);
        check("reset InReady", 32'(inReadyW), 32'd0);
        check("reset Occupancy", 32'(occW[2]), 32'd0);
        rstN = 1'b1;
        cycle();
        check("release InReady", 32'(inReadyW[2]), 32'd1);

        // STAGES=3 streaming, OutReady=1
        outReady = 1'b1;
        inValid = 1'b1;
        inData = 8'h11; cycle();
        check("s3 lat OutValid e1", 32'(outValidW[2]), 32'd0);
        check("s3 InReady e1", 32'(inReadyW[2]), 32'd1);
        inData = 8'h22; cycle();
        check("s3 lat OutValid e2", 32'(outValidW[2]), 32'd0);
        check("s3 InReady e2", 32'(inReadyW[2]), 32'd1);
        inData = 8'h33; cycle();
        check("s3 OutValid e3", 32'(outValidW[2]), 32'd1);
        check("s3 OutData 11", 32'(outDataW[2]), 32'h11);
        check("s3 InReady e3", 32'(inReadyW[2]), 32'd1);
        inData = 8'h44; cycle();
        check("s3 OutData 22", 32'(outDataW[2]), 32'h22);
        inValid = 1'b0;
        cycle();
        check("s3 OutData 33", 32'(outDataW[2]), 32'h33);
        cycle();
        check("s3 OutData 44", 32'(outDataW[2]), 32'h44);
        cycle();
        check("s3 drained", 32'(outValidW[2]), 32'd0);

        // STAGES=2 downstream stall, then drain in order
        doFlush();
        outReady = 1'b0;
        inValid = 1'b1;
        inData = 8'hA0; cycle();
        inData = 8'hA1; cycle();
        inData = 8'hA2; cycle();
        check("s2 stall Occupancy", 32'(occW[1]), 32'd3);
        check("s2 stall InReady", 32'(inReadyW[1]), 32'd0);
        check("s2 stall OutData", 32'(outDataW[1]), 32'hA0);
        inData = 8'hA3; cycle();
        cycle();
        check("s2 held Occupancy", 32'(occW[1]), 32'd3);
        check("s2 held InReady", 32'(inReadyW[1]), 32'd0);
        outReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (outValidW[1]) got.push_back(outDataW[1]);
            acc = inValid && inReadyW[1];
            cycle();
            if (acc) inValid = 1'b0;
        end
        expSeq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        check("s2 drain count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) check($sformatf("s2 drain word %0d", k), 32'(got[k]), 32'(expSeq[k]));
        end
        inValid = 1'b0;

        // STAGES=4 single word, OutReady toggling
        doFlush();
        outReady = 1'b0;
        inValid = 1'b1;
        inData = 8'h05; cycle();
        inValid = 1'b0;
        cycle();
        cycle();
        check("s4 not yet", 32'(outValidW[3]), 32'd0);
        cycle();
        check("s4 arrives", 32'(outValidW[3]), 32'd1);
        check("s4 data", 32'(outDataW[3]), 32'h05);
        deliveries = 0;
        for (int k = 0; k < 16; k++) begin
            outReady = ~outReady;
            if (outValidW[3] && outReady) deliveries++;
            cycle();
        end
        check("s4 delivered once", 32'(deliveries), 32'd1);
        check("s4 Occupancy empty", 32'(occW[3]), 32'd0);

        // Flush while STAGES=2 holds 3 words, with a word offered
        doFlush();
        outReady = 1'b0;
        inValid = 1'b1;
        inData = 8'hB0; cycle();
        inData = 8'hB1; cycle();
        inData = 8'hB2; cycle();
        check("flush pre Occupancy", 32'(occW[1]), 32'd3);
        inData = 8'hFF;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        inValid = 1'b0;
        check("flush OutValid", 32'(outValidW[1]), 32'd0);
        check("flush Occupancy", 32'(occW[1]), 32'd0);
        check("flush InReady", 32'(inReadyW[1]), 32'd1);
        check("flush s4 Occupancy", 32'(occW[3]), 32'd0);
        outReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("flush no output", 32'(outValidW), 32'd0);
        end

        // Asynchronous reset with words in flight
        outReady = 1'b0;
        inValid = 1'b1;
        inData = 8'hC0; cycle();
        inData = 8'hC1; cycle();
        inValid = 1'b0;
        check("inflight Occupancy", 32'(occW[2]), 32'd2);
        check("inflight s1 OutValid", 32'(outValidW[0]), 32'd1);
        #1 rstN = 1'b0;
        #1;
        check("async OutValid", 32'(outValidW), 32'd0);
        check("async OutData s1", 32'(outDataW[0]), 32'd0);
        check("async OutData s3", 32'(outDataW[2]), 32'd0);
        check("async InReady", 32'(inReadyW), 32'd0);
        check("async Occupancy", 32'(occW[2]), 32'd0);
        cycle();
        rstN = 1'b1;
        cycle();
        check("post reset InReady", 32'(inReadyW), 32'hF);
        check("post reset Occupancy", 32'(occW[2]), 32'd0);

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
        // Stall counter: 7 stalled edges, survives Flush, cleared by Reset
        check("perf start", stallW[2], 32'd0);
        outReady = 1'b0;
        inValid = 1'b1;
        inData = 8'hD7; cycle();
        inValid = 1'b0;
        cycle();
        cycle();
        check("perf word at output", 32'(outValidW[2]), 32'd1);
        repeat (7) cycle();
        check("perf seven stalls", stallW[2], 32'd7);
        outReady = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("perf after flush", stallW[2], 32'd7);
        rstN = 1'b0;
        #1;
        check("perf after reset", stallW[2], 32'd0);
        cycle();
        rstN = 1'b1;
        cycle();
`endif

        // Randomized traffic against the models
        for (int k = 0; k < 3000; k++) begin
            inValid  = ($urandom_range(0, 9) < 7);
            inData   = 8'($urandom);
            outReady = ((k / 500) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            flush    = ($urandom_range(0, 99) < 3);
            rstN     = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rstN = 1'b1;
        inValid = 1'b0;
        flush = 1'b0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline register that replaces the fixed, always-advancing inter-stage registers between Fetch/Decode/Execute/Memory/Writeback.
- Carries a WIDTH-bit payload through STAGES register slots with per-slot valid bits and a valid/ready handshake on both sides.
- Collapses bubbles, supports synchronous flush for branch/exception squash, and uses a registered-ready skid entry so InReady has no combinational path from OutReady.

Parameters:
WIDTH, 32, payload width in bits (>=1)
STAGES, 1, number of register slots in the chain (1..8)

Ports:
Clk  input  1  clock, rising-edge
Reset  input  1  asynchronous, active-low reset
InValid  input  1  upstream has a word on InData
InReady  output  1  block can accept a word this cycle (registered)
InData  input  WIDTH  upstream payload
OutValid  output  1  OutData holds a valid word
OutReady  input  1  downstream accepts OutData this cycle
OutData  output  WIDTH  downstream payload
Flush  input  1  synchronous squash of all held words
Occupancy  output  4  number of valid entries (slots plus skid), 0..STAGES+1

Behaviour:
- Storage: slots S[0..STAGES-1] (S[STAGES-1] is the output slot) plus one skid entry K; each has a data register and a valid bit.
- Reset (Reset=0, asynchronous): all valid bits 0, all data registers 0. OutValid=0, OutData=0, Occupancy=0, InReady=0 while Reset is low.
- InReady = Reset_released AND NOT K.valid. It is a registered term only, with no path from OutReady.
- Accept: InValid && InReady at a rising edge.
  - Accepted word goes to S[0] if S[0] is free or advancing in that cycle; otherwise it goes to K.
- Advance rules, all evaluated on current state:
  - Output slot advances when OutReady=1.
  - S[i] moves to S[i+1] when V[i]=1 and (V[i+1]=0 or S[i+1] advancing).
  - Bubbles collapse: a word never waits behind an empty slot.
- K drains into S[0] on the first edge at which S[0] is free or advancing; K clears on that edge.
  - While K is valid, InReady=0, so K and InData never compete.
  - Ordering is strictly FIFO.
- Latency: with the chain empty and OutReady=1, a word accepted at edge k shows OutValid=1 after edge k+STAGES-1 (STAGES=1: visible the cycle after acceptance).
- Throughput: one word per cycle sustained when OutReady=1.
- Downstream stall (OutReady=0): slots fill from the output end back to S[0], then K fills, then InReady drops. Maximum held words = STAGES+1. No word is lost or duplicated.
- OutData is stable while OutValid=1 and OutReady=0.
- Flush=1 at an edge:
  - All valid bits (slots and K) clear.
  - A word offered with InValid && InReady in that cycle is discarded.
  - An output handshake completing in the same cycle counts as consumed.
  - Data registers keep their old contents.
  - On the next cycle: OutValid=0, Occupancy=0, InReady=1.
  - Flush dominates every advance/accept in the same cycle.
- Occupancy: popcount of all valid bits, updated the cycle after each edge. Zero-extended to 4 bits.
- Reset asserted mid-transfer: immediate return to reset state. No partial words survive.

Optional Feature:
Macro PIPE_STAGE_ELASTIC_PERF_EN.
- Defined:
  - Adds output StallCount (32 bits).
  - Increments on every edge where OutValid=1 and OutReady=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by Reset; not cleared by Flush.
- Undefined: port and counter absent, and the block's behaviour is otherwise identical.

Test Plan:
- STAGES=3, OutReady=1, present 0x11,0x22,0x33,0x44 back-to-back -> InReady stays 1; OutValid first rises 2 cycles after the first accept; outputs 0x11..0x44 on consecutive cycles.
- STAGES=2, OutReady=0, push 0xA0,0xA1,0xA2,0xA3 -> three words accepted, Occupancy reaches 3, InReady=0 from the cycle after the third accept, 0xA3 held upstream. Then raise OutReady -> 0xA0,0xA1,0xA2,0xA3 emerge in order, none lost.
- STAGES=4, single word 0x5 then idle, OutReady toggling 0/1 each cycle -> 0x5 collapses forward with no bubble, delivered exactly once; Occupancy returns to 0.
- STAGES=2 holding 3 words, assert Flush together with InValid=1 (0xFF) -> next cycle OutValid=0, Occupancy=0, InReady=1; 0xFF never appears at the output.
- Drop Reset while 2 words are in flight -> OutValid=0, OutData=0, InReady=0 immediately (asynchronously); after release InReady=1 on the first cycle.
- PIPE_STAGE_ELASTIC_PERF_EN defined, OutValid=1 with OutReady=0 for 7 cycles -> StallCount=7; Flush leaves it at 7; Reset clears it to 0.
